// File: rtl/regfile_sb_if.sv
// regfile_sb_if: datapath/control connection for the regfile_sb register file.
//   Read side  : A1..A3 addresses -> RD1..RD3 data, BUSY1..BUSY3 hazard flags
//   PC alias   : R15 supplies the value read at the all-ones address
//   Write side : primary port P (WEP/WAP/WDP), secondary port S (WES/WAS/WDS)
//   Scoreboard : RSV/RSV_A reserve requests, BUSYW WAW flag, COLLIDE, RSV_ERR
// master = control unit / datapath, slave = register file.
interface regfile_sb_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 4
);
    logic [ADDR_W-1:0] A1;
    logic [ADDR_W-1:0] A2;
    logic [ADDR_W-1:0] A3;
    logic [DATA_W-1:0] RD1;
    logic [DATA_W-1:0] RD2;
    logic [DATA_W-1:0] RD3;
    logic [DATA_W-1:0] R15;
    logic              WEP;
    logic [ADDR_W-1:0] WAP;
    logic [DATA_W-1:0] WDP;
    logic              WES;
    logic [ADDR_W-1:0] WAS;
    logic [DATA_W-1:0] WDS;
    logic              RSV;
    logic [ADDR_W-1:0] RSV_A;
    logic              BUSY1;
    logic              BUSY2;
    logic              BUSY3;
    logic              BUSYW;
    logic              COLLIDE;
    logic              RSV_ERR;

    modport master (
        output A1, A2, A3, R15,
        output WEP, WAP, WDP, WES, WAS, WDS, RSV, RSV_A,
        input  RD1, RD2, RD3, BUSY1, BUSY2, BUSY3, BUSYW, COLLIDE, RSV_ERR
    );

    modport slave (
        input  A1, A2, A3, R15,
        input  WEP, WAP, WDP, WES, WAS, WDS, RSV, RSV_A,
        output RD1, RD2, RD3, BUSY1, BUSY2, BUSY3, BUSYW, COLLIDE, RSV_ERR
    );
endinterface

// File: rtl/regfile_sb.sv
// regfile_sb: three-read, two-write register file with a pending-write
// scoreboard for multi-cycle results.
// Ports:
//   CLK    - rising-edge clock
//   RESETn - asynchronous active-low reset (clears scoreboard and flags,
//            and the register bank too when RST_CLEAR = 1)
//   bus    - regfile_sb_if slave: read ports, P/S write ports, reservation
//            requests and the BUSY*/COLLIDE/RSV_ERR status outputs
// The all-ones address aliases the PC: reads return R15, writes and
// reservations to it are ignored.
module regfile_sb #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 4,
    parameter bit          BYPASS    = 1'b1,
    parameter bit          RST_CLEAR = 1'b1
) (
    input logic         CLK,
    input logic         RESETn,
    regfile_sb_if.slave bus
);
    localparam int unsigned NREG    = (1 << ADDR_W) - 1;
    localparam int unsigned NRD     = 3;
    localparam logic [ADDR_W-1:0] PC_ADDR = '1;

    logic [DATA_W-1:0] regs [NREG];
    logic [NREG-1:0]   pending;
    logic [NREG-1:0]   pending_nxt;
    logic              collide_q;
    logic              rsv_err_q;

    // Per-register address decodes. Physical indices stop below PC_ADDR,
    // so PC-targeted writes/reservations decode to nothing.
    logic [NREG-1:0]   hit_p;
    logic [NREG-1:0]   hit_s;
    logic [NREG-1:0]   hit_rsv;

    logic [ADDR_W-1:0] raddr [NRD];
    logic [DATA_W-1:0] rdata [NRD];
    logic              rbusy [NRD];
    logic              busy_w;
    logic              collide_nxt;
    logic              rsv_err_set;

    always_comb begin
        hit_p   = '0;
        hit_s   = '0;
        hit_rsv = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
            hit_p[i]   = bus.WEP && (bus.WAP == ADDR_W'(i));
            hit_s[i]   = bus.WES && (bus.WAS == ADDR_W'(i));
            hit_rsv[i] = bus.RSV && (bus.RSV_A == ADDR_W'(i));
        end
    end

    // Register bank. P has priority over S on a same-address double write.
    if (RST_CLEAR) begin : g_bank_clr
        always_ff @(posedge CLK or negedge RESETn) begin
            if (!RESETn) begin
                for (int unsigned i = 0; i < NREG; i++) begin
                    regs[i] <= '0;
                end
            end else begin
                for (int unsigned i = 0; i < NREG; i++) begin
                    if (hit_p[i]) begin
                        regs[i] <= bus.WDP;
                    end else if (hit_s[i]) begin
                        regs[i] <= bus.WDS;
                    end
                end
            end
        end
    end else begin : g_bank_keep
        always_ff @(posedge CLK) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                if (hit_p[i]) begin
                    regs[i] <= bus.WDP;
                end else if (hit_s[i]) begin
                    regs[i] <= bus.WDS;
                end
            end
        end
    end

    // Scoreboard next state. A reservation on a clear bit wins over a
    // same-cycle completion; on a set bit the completion clears it and
    // the reservation only raises the error flag.
    always_comb begin
        pending_nxt = pending;
        rsv_err_set = 1'b0;
        for (int unsigned i = 0; i < NREG; i++) begin
            if (hit_rsv[i] && !pending[i]) begin
                pending_nxt[i] = 1'b1;
            end else if (hit_s[i]) begin
                pending_nxt[i] = 1'b0;
            end
            if (hit_rsv[i] && pending[i]) begin
                rsv_err_set = 1'b1;
            end
        end
    end

    assign collide_nxt = bus.WEP && bus.WES && (bus.WAP == bus.WAS) &&
                         (bus.WAP != PC_ADDR);

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            pending   <= '0;
            collide_q <= 1'b0;
            rsv_err_q <= 1'b0;
        end else begin
            pending   <= pending_nxt;
            collide_q <= collide_nxt;
            rsv_err_q <= rsv_err_q | rsv_err_set;
        end
    end

    // Read ports: stored value and pending bit by decode, then bypass
    // (S first so P overrides it), then the PC alias over everything.
    assign raddr[0] = bus.A1;
    assign raddr[1] = bus.A2;
    assign raddr[2] = bus.A3;

    always_comb begin
        for (int unsigned j = 0; j < NRD; j++) begin
            rdata[j] = '0;
            rbusy[j] = 1'b0;
            for (int unsigned i = 0; i < NREG; i++) begin
                if (raddr[j] == ADDR_W'(i)) begin
                    rdata[j] = regs[i];
                    rbusy[j] = pending[i];
                end
            end
            if (BYPASS) begin
                if (bus.WES && (bus.WAS == raddr[j])) begin
                    rdata[j] = bus.WDS;
                end
                if (bus.WEP && (bus.WAP == raddr[j])) begin
                    rdata[j] = bus.WDP;
                end
            end
            if (raddr[j] == PC_ADDR) begin
                rdata[j] = bus.R15;
            end
        end
    end

    // WAW flag looks only at the registered pending state.
    always_comb begin
        busy_w = 1'b0;
        for (int unsigned i = 0; i < NREG; i++) begin
            if (hit_p[i] && pending[i]) begin
                busy_w = 1'b1;
            end
        end
    end

    assign bus.RD1     = rdata[0];
    assign bus.RD2     = rdata[1];
    assign bus.RD3     = rdata[2];
    assign bus.BUSY1   = rbusy[0];
    assign bus.BUSY2   = rbusy[1];
    assign bus.BUSY3   = rbusy[2];
    assign bus.BUSYW   = busy_w;
    assign bus.COLLIDE = collide_q;
    assign bus.RSV_ERR = rsv_err_q;

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: scoreboard bench for regfile_sb. A driver applies one
// stimulus vector per cycle, predicts the combinational outputs from an
// array-based model and queues the prediction; a monitor pops each
// prediction and compares it with the DUT outputs.
module tb_regfile_sb;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned ADDR_W    = 4;
    localparam bit          BYPASS    = 1'b1;
    localparam bit          RST_CLEAR = 1'b1;
    localparam int unsigned PC        = 15;

    typedef struct {
        logic [3:0]  a1, a2, a3;
        logic [31:0] r15;
        logic        wep;
        logic [3:0]  wap;
        logic [31:0] wdp;
        logic        wes;
        logic [3:0]  was;
        logic [31:0] wds;
        logic        rsv;
        logic [3:0]  rsv_a;
        logic        rst_pulse;
    } stim_t;

    typedef struct {
        logic [31:0] rd1, rd2, rd3;
        bit          k1, k2, k3;
        logic        busy1, busy2, busy3, busyw, collide, rsv_err;
    } exp_t;

    logic clk;
    logic rst_n;

    regfile_sb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    regfile_sb #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .BYPASS(BYPASS),
        .RST_CLEAR(RST_CLEAR)
    ) dut (
        .CLK(clk),
        .RESETn(rst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] m_reg   [16];
    bit          m_known [16];
    bit          m_pend  [16];
    bit          m_collide;
    bit          m_err;

    exp_t exp_q [$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_pend[i] = 0;
            if (RST_CLEAR) begin
                m_reg[i]   = '0;
                m_known[i] = 1;
            end
        end
        m_collide = 0;
        m_err     = 0;
    endtask

    function automatic logic [31:0] m_read(input stim_t s, input logic [3:0] a,
                                           output bit known);
        known = 1;
        if (a == PC) return s.r15;
        if (BYPASS && s.wep && s.wap == a) return s.wdp;
        if (BYPASS && s.wes && s.was == a) return s.wds;
        known = m_known[a];
        return m_reg[a];
    endfunction

    function automatic exp_t predict(input stim_t s);
        exp_t e;
        e.rd1     = m_read(s, s.a1, e.k1);
        e.rd2     = m_read(s, s.a2, e.k2);
        e.rd3     = m_read(s, s.a3, e.k3);
        e.busy1   = (s.a1 != PC) && m_pend[s.a1];
        e.busy2   = (s.a2 != PC) && m_pend[s.a2];
        e.busy3   = (s.a3 != PC) && m_pend[s.a3];
        e.busyw   = s.wep && (s.wap != PC) && m_pend[s.wap];
        e.collide = m_collide;
        e.rsv_err = m_err;
        return e;
    endfunction

    task automatic model_clock(input stim_t s);
        bit was_pending;
        was_pending = (s.rsv_a != PC) && m_pend[s.rsv_a];
        if (s.wes && s.was != PC) begin
            m_reg[s.was]   = s.wds;
            m_known[s.was] = 1;
            m_pend[s.was]  = 0;
        end
        if (s.wep && s.wap != PC) begin
            m_reg[s.wap]   = s.wdp;
            m_known[s.wap] = 1;
        end
        m_collide = s.wep && s.wes && (s.wap == s.was) && (s.wap != PC);
        if (s.rsv && s.rsv_a != PC) begin
            if (was_pending) m_err = 1;
            else m_pend[s.rsv_a] = 1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
        end
    endtask

    // Monitor: each queued prediction is checked 1 ns after it is issued,
    // while the inputs that produced it are still applied.
    initial begin
        exp_t e;
        forever begin
            wait (exp_q.size() > 0);
            #1;
            e = exp_q.pop_front();
            if (e.k1) chk("RD1", bus.RD1, e.rd1);
            if (e.k2) chk("RD2", bus.RD2, e.rd2);
            if (e.k3) chk("RD3", bus.RD3, e.rd3);
            chk("BUSY1", 32'(bus.BUSY1), 32'(e.busy1));
            chk("BUSY2", 32'(bus.BUSY2), 32'(e.busy2));
            chk("BUSY3", 32'(bus.BUSY3), 32'(e.busy3));
            chk("BUSYW", 32'(bus.BUSYW), 32'(e.busyw));
            chk("COLLIDE", 32'(bus.COLLIDE), 32'(e.collide));
            chk("RSV_ERR", 32'(bus.RSV_ERR), 32'(e.rsv_err));
        end
    end

    task automatic run(input stim_t s);
        @(negedge clk);
        bus.A1    = s.a1;
        bus.A2    = s.a2;
        bus.A3    = s.a3;
        bus.R15   = s.r15;
        bus.WEP   = s.wep;
        bus.WAP   = s.wap;
        bus.WDP   = s.wdp;
        bus.WES   = s.wes;
        bus.WAS   = s.was;
        bus.WDS   = s.wds;
        bus.RSV   = s.rsv;
        bus.RSV_A = s.rsv_a;
        if (s.rst_pulse) rst_n = 1'b0;
        #1;
        if (s.rst_pulse) model_reset();
        exp_q.push_back(predict(s));
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        model_clock(s);
    endtask

    function automatic stim_t idle(input logic [3:0] a1, input logic [3:0] a2,
                                   input logic [3:0] a3);
        stim_t s;
        s = '{a1: a1, a2: a2, a3: a3, r15: 32'h0000_0108, wep: 0, wap: 0,
              wdp: 0, wes: 0, was: 0, wds: 0, rsv: 0, rsv_a: 0, rst_pulse: 0};
        return s;
    endfunction

    function automatic stim_t rnd();
        stim_t s;
        s.a1        = 4'($urandom_range(0, 15));
        s.a2        = 4'($urandom_range(0, 15));
        s.a3        = 4'($urandom_range(0, 15));
        s.r15       = $urandom;
        s.wep       = 1'($urandom_range(0, 1));
        s.wap       = 4'($urandom_range(0, 15));
        s.wdp       = $urandom;
        s.wes       = ($urandom_range(0, 3) == 0);
        s.was       = 4'($urandom_range(0, 15));
        s.wds       = $urandom;
        s.rsv       = ($urandom_range(0, 3) == 0);
        s.rsv_a     = 4'($urandom_range(0, 15));
        s.rst_pulse = ($urandom_range(0, 63) == 0);
        return s;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not complete in time");
        $fatal(1);
    end

    initial begin
        stim_t s;
        rst_n = 1'b0;
        bus.A1 = '0; bus.A2 = '0; bus.A3 = '0; bus.R15 = '0;
        bus.WEP = 1'b0; bus.WAP = '0; bus.WDP = '0;
        bus.WES = 1'b0; bus.WAS = '0; bus.WDS = '0;
        bus.RSV = 1'b0; bus.RSV_A = '0;
        for (int i = 0; i < 16; i++) begin
            m_reg[i] = 'x; m_known[i] = 0; m_pend[i] = 0;
        end
        m_collide = 0; m_err = 0;
        repeat (2) @(posedge clk);

        // Reset then read
        s = idle(0, 14, 15); s.rst_pulse = 1; run(s);
        // Write with bypass, then stored value
        s = idle(3, 0, 0); s.wep = 1; s.wap = 3; s.wdp = 32'hDEAD_BEEF; run(s);
        s = idle(3, 0, 0); run(s);
        // Write to PC alias is dropped
        s = idle(15, 3, 0); s.wep = 1; s.wap = 15; s.wdp = 32'h1234; run(s);
        s = idle(3, 15, 0); s.r15 = 32'h0000_0200; run(s);
        // Collision: P wins, COLLIDE for one cycle
        s = idle(5, 0, 0); s.wep = 1; s.wes = 1; s.wap = 5; s.was = 5;
        s.wdp = 32'h11; s.wds = 32'h22; run(s);
        s = idle(5, 0, 0); run(s);
        s = idle(5, 0, 0); run(s);
        // Reserve 7, stall flags, complete with WES
        s = idle(0, 0, 0); s.rsv = 1; s.rsv_a = 7; run(s);
        s = idle(0, 7, 0); s.wep = 1; s.wap = 7; s.wdp = 32'h77; run(s);
        s = idle(0, 7, 7); s.wes = 1; s.was = 7; s.wds = 32'hCAFE; run(s);
        s = idle(0, 7, 0); run(s);
        // Double reserve on 9, then same-cycle RSV+WES on pending 9
        s = idle(9, 0, 0); s.rsv = 1; s.rsv_a = 9; run(s);
        s = idle(9, 0, 0); s.rsv = 1; s.rsv_a = 9; run(s);
        s = idle(9, 0, 0); s.rsv = 1; s.rsv_a = 9; s.wes = 1; s.was = 9;
        s.wds = 32'h99; run(s);
        s = idle(9, 0, 0); run(s);
        // Same-cycle RSV+WES on a clear register: reservation wins
        s = idle(10, 0, 0); s.rsv = 1; s.rsv_a = 10; s.wes = 1; s.was = 10;
        s.wds = 32'hAA; run(s);
        s = idle(10, 0, 0); s.rsv = 1; s.rsv_a = 15; run(s);
        // Async reset mid-operation with 4 and 6 pending
        s = idle(0, 0, 0); s.rsv = 1; s.rsv_a = 4; s.wep = 1; s.wap = 4;
        s.wdp = 32'h55; run(s);
        s = idle(0, 0, 0); s.rsv = 1; s.rsv_a = 6; run(s);
        s = idle(4, 6, 10); run(s);
        s = idle(4, 6, 10); s.rst_pulse = 1; run(s);
        s = idle(4, 6, 0); s.wes = 1; s.was = 4; s.wds = 32'h44; run(s);
        s = idle(4, 6, 0); run(s);

        // Randomised traffic
        for (int n = 0; n < 400; n++) begin
            run(rnd());
        end

        #20;
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d predictions left unchecked, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
